// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  // Request FSM: IDLE = no request, REQ = request whose response is kept,
  // DROP = request whose response is discarded after a redirect.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  // Byte distance between consecutive instruction words.
  localparam int FETCH_STEP = 4;

  // Default fetch address after reset.
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with registered head output and flush.
// Flush wins over push and pop; pop on empty is ignored; push when full is
// accepted only if a pop frees a slot on the same edge.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           head_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [WIDTH-1:0] head_reg, head_next;
  logic             do_push, do_pop;
  logic [DEPTH-1:0] wr_en;

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;
  assign head_data = head_reg;

  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  // Per-entry write enable decoded from the write pointer.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = do_push && (wr_ptr_reg == PTR_W'(gi));
  end

  // Next pointers, occupancy and the word that will sit at the head.
  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    head_next   = head_reg;
    if (flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      rd_ptr_next = rd_ptr_reg + PTR_W'(do_pop);
      wr_ptr_next = wr_ptr_reg + PTR_W'(do_push);
      count_next  = count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
      // The head only changes when something remains; otherwise it holds
      // the last presented word. A write landing on the new read slot means
      // the FIFO drained to zero first, so the pushed word becomes the head.
      if (count_next != '0) begin
        if (do_push && (wr_ptr_reg == rd_ptr_next)) begin
          head_next = push_data;
        end else begin
          head_next = mem_reg[rd_ptr_next];
        end
      end
    end
  end

  // Storage array: written only, no reset needed.
  always_ff @(posedge Clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) begin
        mem_reg[i] <= push_data;
      end
    end
  end

  // Pointer, count and head registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      head_reg   <= head_next;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, requests words from
// instruction memory over req/ack, buffers them with their PCs and hands
// them to decode over valid/ready. A redirect flushes the buffer and drops
// any response still outstanding for the old path.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              ADDR_W     = 32,
  parameter int              DATA_W     = 32,
  parameter int              FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] RedirectAddr,
  output logic              MemReq,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic              MemAck,
  input  logic [DATA_W-1:0] MemRdata,
  output logic              InstrValid,
  output logic [DATA_W-1:0] Instr,
  output logic [ADDR_W-1:0] InstrPC,
  input  logic              InstrReady,
  output logic [ADDR_W-1:0] FetchPC
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;

  logic                     fifo_full, fifo_empty;
  logic [CNT_W-1:0]         fifo_count;
  logic [ADDR_W+DATA_W-1:0] fifo_head;

  logic              push_fire, pop_fire, full_after;
  logic [ADDR_W-1:0] redirect_pc, pc_plus_step;

  assign redirect_pc  = {RedirectAddr[ADDR_W-1:2], 2'b00};
  assign pc_plus_step = fetch_pc_reg + ADDR_W'(FETCH_STEP);

  // A kept response is pushed only outside a redirect; a redirect also
  // suppresses the pop because the whole buffer is being discarded.
  assign push_fire  = (state_reg == REQ) && MemAck && !Redirect;
  assign pop_fire   = !fifo_empty && InstrReady && !Redirect;
  assign full_after = (fifo_count + CNT_W'(push_fire) - CNT_W'(pop_fire))
                      == CNT_W'(FIFO_DEPTH);

  // Next-state, next fetch PC and next request address.
  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    mem_addr_next = mem_addr_reg;
    case (state_reg)
      IDLE: begin
        if (Redirect) begin
          fetch_pc_next = redirect_pc;
          mem_addr_next = redirect_pc;
          state_next    = REQ;
        end else if (!fifo_full || pop_fire) begin
          mem_addr_next = fetch_pc_reg;
          state_next    = REQ;
        end
      end
      REQ: begin
        if (Redirect) begin
          fetch_pc_next = redirect_pc;
          if (MemAck) begin
            // The acked word belongs to the old path; start the new one.
            mem_addr_next = redirect_pc;
            state_next    = REQ;
          end else begin
            // The request cannot be retracted; wait for it and discard it.
            state_next = DROP;
          end
        end else if (MemAck) begin
          fetch_pc_next = pc_plus_step;
          if (full_after) begin
            state_next = IDLE;
          end else begin
            mem_addr_next = pc_plus_step;
          end
        end
      end
      DROP: begin
        if (Redirect) begin
          fetch_pc_next = redirect_pc;
        end
        if (MemAck) begin
          mem_addr_next = Redirect ? redirect_pc : fetch_pc_reg;
          state_next    = REQ;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM, fetch PC and request address registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= RESET_PC;
      mem_addr_reg <= RESET_PC;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      mem_addr_reg <= mem_addr_next;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_fifo (
    .Clk       (Clk),
    .Reset     (Reset),
    .push      (push_fire),
    .push_data ({mem_addr_reg, MemRdata}),
    .pop       (InstrReady),
    .flush     (Redirect),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head_data (fifo_head)
  );

  assign MemReq     = (state_reg != IDLE);
  assign MemAddr    = mem_addr_reg;
  assign FetchPC    = fetch_pc_reg;
  assign InstrValid = !fifo_empty;
  assign InstrPC    = fifo_head[ADDR_W+DATA_W-1:DATA_W];
  assign Instr      = fifo_head[DATA_W-1:0];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_instruction_fetch_unit;
  import fetch_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Redirect = 1'b0;
  logic [31:0] RedirectAddr = '0;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemAck = 1'b0;
  logic [31:0] MemRdata;
  logic        InstrValid;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic        InstrReady = 1'b0;
  logic [31:0] FetchPC;

  int checks = 0;
  int failures = 0;

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_F00D;
  endfunction

  assign MemRdata = word_of(MemAddr);

  always #5 Clk = ~Clk;

  instruction_fetch_unit dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Redirect     (Redirect),
    .RedirectAddr (RedirectAddr),
    .MemReq       (MemReq),
    .MemAddr      (MemAddr),
    .MemAck       (MemAck),
    .MemRdata     (MemRdata),
    .InstrValid   (InstrValid),
    .Instr        (Instr),
    .InstrPC      (InstrPC),
    .InstrReady   (InstrReady),
    .FetchPC      (FetchPC)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Hold reset for two cycles and release it on a falling edge.
  task automatic do_reset();
    Reset = 1'b1; Redirect = 1'b0; MemAck = 1'b0; InstrReady = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    @(negedge Clk);
    checks++; if (MemReq !== 1'b0) begin failures++; $display("FAIL rst_memreq got=%0b exp=0", MemReq); end
    checks++; if (MemAddr !== 32'h0) begin failures++; $display("FAIL rst_memaddr got=%h exp=%h", MemAddr, 32'h0); end
    checks++; if (FetchPC !== 32'h0) begin failures++; $display("FAIL rst_fetchpc got=%h exp=%h", FetchPC, 32'h0); end
    checks++; if (InstrValid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", InstrValid); end
    checks++; if (Instr !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=%h", Instr, 32'h0); end
    checks++; if (InstrPC !== 32'h0) begin failures++; $display("FAIL rst_instrpc got=%h exp=%h", InstrPC, 32'h0); end
    $display("test_reset done");
  endtask

  task automatic test_stream();
    do_reset();
    MemAck = 1'b1; InstrReady = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge Clk);
      checks++; if (MemReq !== 1'b1) begin failures++; $display("FAIL stream_req n=%0d got=%0b exp=1", n, MemReq); end
      checks++; if (MemAddr !== 32'(4 * (n - 1))) begin failures++; $display("FAIL stream_addr n=%0d got=%h exp=%h", n, MemAddr, 32'(4 * (n - 1))); end
      if (n >= 2) begin
        checks++; if (InstrValid !== 1'b1) begin failures++; $display("FAIL stream_valid n=%0d got=%0b exp=1", n, InstrValid); end
        checks++; if (InstrPC !== 32'(4 * (n - 2))) begin failures++; $display("FAIL stream_pc n=%0d got=%h exp=%h", n, InstrPC, 32'(4 * (n - 2))); end
        checks++; if (Instr !== word_of(32'(4 * (n - 2)))) begin failures++; $display("FAIL stream_instr n=%0d got=%h exp=%h", n, Instr, word_of(32'(4 * (n - 2)))); end
        $display("stream: pc=%h instr=%h", InstrPC, Instr);
      end else begin
        checks++; if (InstrValid !== 1'b0) begin failures++; $display("FAIL stream_first_valid got=%0b exp=0", InstrValid); end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    MemAck = 1'b1; InstrReady = 1'b0;
    repeat (5) @(negedge Clk);
    for (int i = 0; i < 2; i++) begin
      checks++; if (MemReq !== 1'b0) begin failures++; $display("FAIL bp_full_req got=%0b exp=0", MemReq); end
      checks++; if (InstrValid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%0b exp=1", InstrValid); end
      checks++; if (InstrPC !== 32'h0) begin failures++; $display("FAIL bp_head got=%h exp=%h", InstrPC, 32'h0); end
      @(negedge Clk);
    end
    InstrReady = 1'b1;
    @(negedge Clk);
    InstrReady = 1'b0; MemAck = 1'b0;
    checks++; if (MemReq !== 1'b1) begin failures++; $display("FAIL bp_refetch_req got=%0b exp=1", MemReq); end
    checks++; if (MemAddr !== 32'h8) begin failures++; $display("FAIL bp_refetch_addr got=%h exp=%h", MemAddr, 32'h8); end
    checks++; if (InstrPC !== 32'h4) begin failures++; $display("FAIL bp_second got=%h exp=%h", InstrPC, 32'h4); end
    @(negedge Clk);
    checks++; if (MemAddr !== 32'h8) begin failures++; $display("FAIL bp_hold_addr got=%h exp=%h", MemAddr, 32'h8); end
    checks++; if (InstrPC !== 32'h4) begin failures++; $display("FAIL bp_hold_head got=%h exp=%h", InstrPC, 32'h4); end
    $display("backpressure: refetch at %h", MemAddr);
  endtask

  task automatic test_ack_delay();
    do_reset();
    MemAck = 1'b0; InstrReady = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      @(negedge Clk);
      checks++; if (MemReq !== 1'b1) begin failures++; $display("FAIL delay_req n=%0d got=%0b exp=1", n, MemReq); end
      checks++; if (MemAddr !== 32'h0) begin failures++; $display("FAIL delay_addr n=%0d got=%h exp=%h", n, MemAddr, 32'h0); end
      checks++; if (InstrValid !== 1'b0) begin failures++; $display("FAIL delay_valid n=%0d got=%0b exp=0", n, InstrValid); end
    end
    MemAck = 1'b1;
    @(negedge Clk);
    MemAck = 1'b0;
    checks++; if (InstrValid !== 1'b1) begin failures++; $display("FAIL delay_push_valid got=%0b exp=1", InstrValid); end
    checks++; if (InstrPC !== 32'h0) begin failures++; $display("FAIL delay_push_pc got=%h exp=%h", InstrPC, 32'h0); end
    checks++; if (MemAddr !== 32'h4) begin failures++; $display("FAIL delay_next_addr got=%h exp=%h", MemAddr, 32'h4); end
    @(negedge Clk);
    checks++; if (InstrValid !== 1'b0) begin failures++; $display("FAIL delay_single_push got=%0b exp=0", InstrValid); end
    $display("ack_delay: one word at %h", 32'h0);
  endtask

  task automatic test_redirect_drop();
    do_reset();
    MemAck = 1'b1; InstrReady = 1'b1;
    repeat (3) @(negedge Clk);
    checks++; if (MemAddr !== 32'h8) begin failures++; $display("FAIL drop_pre_addr got=%h exp=%h", MemAddr, 32'h8); end
    MemAck = 1'b0; Redirect = 1'b1; RedirectAddr = 32'h103;
    @(negedge Clk);
    Redirect = 1'b0; RedirectAddr = $urandom;
    checks++; if (MemReq !== 1'b1) begin failures++; $display("FAIL drop_req got=%0b exp=1", MemReq); end
    checks++; if (MemAddr !== 32'h8) begin failures++; $display("FAIL drop_old_addr got=%h exp=%h", MemAddr, 32'h8); end
    checks++; if (InstrValid !== 1'b0) begin failures++; $display("FAIL drop_flush got=%0b exp=0", InstrValid); end
    checks++; if (FetchPC !== 32'h100) begin failures++; $display("FAIL drop_fetchpc got=%h exp=%h", FetchPC, 32'h100); end
    MemAck = 1'b1;
    @(negedge Clk);
    checks++; if (MemAddr !== 32'h100) begin failures++; $display("FAIL drop_new_addr got=%h exp=%h", MemAddr, 32'h100); end
    checks++; if (InstrValid !== 1'b0) begin failures++; $display("FAIL drop_discard got=%0b exp=0", InstrValid); end
    @(negedge Clk);
    checks++; if (InstrValid !== 1'b1) begin failures++; $display("FAIL drop_first_valid got=%0b exp=1", InstrValid); end
    checks++; if (InstrPC !== 32'h100) begin failures++; $display("FAIL drop_first_pc got=%h exp=%h", InstrPC, 32'h100); end
    checks++; if (Instr !== word_of(32'h100)) begin failures++; $display("FAIL drop_first_instr got=%h exp=%h", Instr, word_of(32'h100)); end
    $display("redirect_drop: first pc=%h", InstrPC);
  endtask

  task automatic test_redirect_ack_pop();
    do_reset();
    MemAck = 1'b1; InstrReady = 1'b1;
    repeat (2) @(negedge Clk);
    checks++; if (InstrValid !== 1'b1) begin failures++; $display("FAIL rap_pre_valid got=%0b exp=1", InstrValid); end
    checks++; if (MemAddr !== 32'h4) begin failures++; $display("FAIL rap_pre_addr got=%h exp=%h", MemAddr, 32'h4); end
    Redirect = 1'b1; RedirectAddr = 32'h202;
    @(negedge Clk);
    Redirect = 1'b0;
    checks++; if (InstrValid !== 1'b0) begin failures++; $display("FAIL rap_empty got=%0b exp=0", InstrValid); end
    checks++; if (MemAddr !== 32'h200) begin failures++; $display("FAIL rap_addr got=%h exp=%h", MemAddr, 32'h200); end
    checks++; if (FetchPC !== 32'h200) begin failures++; $display("FAIL rap_fetchpc got=%h exp=%h", FetchPC, 32'h200); end
    @(negedge Clk);
    checks++; if (InstrValid !== 1'b1) begin failures++; $display("FAIL rap_valid got=%0b exp=1", InstrValid); end
    checks++; if (InstrPC !== 32'h200) begin failures++; $display("FAIL rap_pc got=%h exp=%h", InstrPC, 32'h200); end
    $display("redirect_ack_pop: first pc=%h", InstrPC);
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    MemAck = 1'b1; InstrReady = 1'b1;
    @(negedge Clk);
    Redirect = 1'b1; RedirectAddr = 32'hFFFF_FFFE;
    @(negedge Clk);
    Redirect = 1'b0;
    checks++; if (MemAddr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr got=%h exp=%h", MemAddr, 32'hFFFF_FFFC); end
    @(negedge Clk);
    checks++; if (InstrPC !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pc_top got=%h exp=%h", InstrPC, 32'hFFFF_FFFC); end
    checks++; if (MemAddr !== 32'h0) begin failures++; $display("FAIL wrap_addr_zero got=%h exp=%h", MemAddr, 32'h0); end
    @(negedge Clk);
    checks++; if (InstrPC !== 32'h0) begin failures++; $display("FAIL wrap_pc_zero got=%h exp=%h", InstrPC, 32'h0); end
    MemAck = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    checks++; if (MemReq !== 1'b0) begin failures++; $display("FAIL async_rst_req got=%0b exp=0", MemReq); end
    checks++; if (InstrValid !== 1'b0) begin failures++; $display("FAIL async_rst_valid got=%0b exp=0", InstrValid); end
    checks++; if (MemAddr !== 32'h0) begin failures++; $display("FAIL async_rst_addr got=%h exp=%h", MemAddr, 32'h0); end
    @(negedge Clk);
    Reset = 1'b0; MemAck = 1'b1;
    @(negedge Clk);
    checks++; if (MemReq !== 1'b1) begin failures++; $display("FAIL restart_req got=%0b exp=1", MemReq); end
    checks++; if (MemAddr !== 32'h0) begin failures++; $display("FAIL restart_addr got=%h exp=%h", MemAddr, 32'h0); end
    @(negedge Clk);
    checks++; if (InstrPC !== 32'h0 || InstrValid !== 1'b1) begin failures++; $display("FAIL restart_pc got=%h/%0b exp=%h/1", InstrPC, InstrValid, 32'h0); end
    $display("wrap_and_reset: restarted at %h", InstrPC);
  endtask

  // Randomized run. The model is the architectural view: the instruction
  // stream from exp_pc onward, a queue of delivered-but-unconsumed words,
  // and a flag saying the outstanding request belongs to an abandoned path.
  task automatic test_random();
    fetch_entry_t q[$];
    fetch_entry_t e;
    logic [31:0] exp_pc = 32'h0;
    logic        drop_pending = 1'b0;
    logic        hold_prev = 1'b0;
    logic [31:0] prev_addr = '0;
    int          pushes = 0;
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge Clk);
      checks++; if (InstrValid !== (q.size() != 0)) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", cyc, InstrValid, q.size() != 0); end
      checks++; if (FetchPC !== exp_pc) begin failures++; $display("FAIL rnd_fetchpc cyc=%0d got=%h exp=%h", cyc, FetchPC, exp_pc); end
      if (q.size() != 0) begin
        checks++; if (InstrPC !== q[0].pc || Instr !== q[0].instr) begin failures++; $display("FAIL rnd_head cyc=%0d got=%h:%h exp=%h:%h", cyc, InstrPC, Instr, q[0].pc, q[0].instr); end
      end
      if (hold_prev) begin
        checks++; if (MemReq !== 1'b1 || MemAddr !== prev_addr) begin failures++; $display("FAIL rnd_req_stable cyc=%0d got=%0b:%h exp=1:%h", cyc, MemReq, MemAddr, prev_addr); end
      end
      MemAck     = 1'($urandom % 2);
      InstrReady = (($urandom % 10) < 6);
      Redirect   = (($urandom % 20) == 0);
      RedirectAddr = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 + ($urandom % 16)) : $urandom;
      hold_prev = MemReq && !MemAck;
      prev_addr = MemAddr;
      if (Redirect) begin
        q.delete();
        exp_pc = RedirectAddr & 32'hFFFF_FFFC;
        drop_pending = MemReq && !MemAck;
      end else begin
        if (q.size() != 0 && InstrReady) void'(q.pop_front());
        if (MemReq && MemAck) begin
          if (drop_pending) begin
            drop_pending = 1'b0;
          end else begin
            checks++; if (MemAddr !== exp_pc) begin failures++; $display("FAIL rnd_req_addr cyc=%0d got=%h exp=%h", cyc, MemAddr, exp_pc); end
            e.pc = exp_pc;
            e.instr = word_of(exp_pc);
            q.push_back(e);
            exp_pc = exp_pc + 32'd4;
            pushes++;
          end
        end
      end
      checks++; if (q.size() > 2) begin failures++; $display("FAIL rnd_overflow cyc=%0d got=%0d exp<=2", cyc, q.size()); end
    end
    @(negedge Clk);
    Redirect = 1'b0; MemAck = 1'b0; InstrReady = 1'b0;
    checks++; if (pushes < 50) begin failures++; $display("FAIL rnd_progress got=%0d exp>=50", pushes); end
    $display("random: %0d words delivered", pushes);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_ack_delay();
    test_redirect_drop();
    test_redirect_ack_pop();
    test_wrap_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
